multicore_io_arbiter: RTL

//   Parametrised switch/display arbiter for the N-core RISC621 system.

---
 rtl/mcio_pkg.sv | 21 ++
 rtl/mcio_debounce.sv | 37 +++
 rtl/multicore_io_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mcio_pkg.sv
// mcio_pkg: shared definitions for the multicore I/O arbiter.
//   - State encoding of the ownership FSM (INPUT=0, WAIT=1, DISPLAY=2, COMPLETE=3).
//   - Bit replicated across the display bus once every core has been served.
package mcio_pkg;

    localparam logic [1:0] ST_INPUT    = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_DISPLAY  = 2'd2;
    localparam logic [1:0] ST_COMPLETE = 2'd3;

    typedef enum logic [1:0] {
        S_INPUT    = ST_INPUT,
        S_WAIT     = ST_WAIT,
        S_DISPLAY  = ST_DISPLAY,
        S_COMPLETE = ST_COMPLETE
    } mcio_state_t;

    // The COMPLETE display pattern is this bit replicated DISP_W times (all ones).
    localparam logic COMPLETE_DISP_BIT = 1'b1;

endpackage

// File: rtl/mcio_debounce.sv
// mcio_debounce: single-bit debouncer.
//   The output follows the input only after the input has differed from the
//   output for DEB_CYCLES consecutive clocks; shorter glitches are dropped.
// Ports:
//   Clock_pin  in   system clock
//   Reset_pin  in   synchronous active-high reset (output and counter cleared)
//   din        in   synchronised raw bit
//   dout       out  debounced bit (registered)
module mcio_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic Clock_pin,
    input  logic Reset_pin,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din == dout) begin
            // Any return to the current level restarts the stability window.
            cnt <= '0;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicore_io_arbiter.sv
// multicore_io_arbiter: switch/display arbiter for an N-core RISC621 system.
//   While cores compute, the synchronised switches are broadcast to every core.
//   Once every core reports Done, switches and display are handed to one core
//   at a time; the owner advances after OPS_PER_CORE releases of the step
//   button (SW bit0). After the last core, the block parks in COMPLETE.
// Configuration macro:
//   MCIO_DEBOUNCE_EN  - when defined, synchronised SW bit0 is debounced over
//                       DEB_CYCLES clocks before edge detection and use.
// Ports:
//   Clock_pin    in   system clock
//   Reset_pin    in   synchronous active-high reset
//   SW_pin       in   raw switches, bit0 = step button
//   core_done    in   Done flag per core
//   core_disp    in   display bus per core, core i at [i*DISP_W +: DISP_W]
//   core_sw      out  switch bus per core, same packing (registered)
//   Display_pin  out  LED output (registered)
//   sel_core     out  index of the current display owner
//   all_done     out  high while in COMPLETE (registered)
//   state_dbg    out  current FSM state encoding (mcio_pkg ST_*)
module multicore_io_arbiter
    import mcio_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int IDX_W        = 2,
    parameter int SW_W         = 5,
    parameter int DISP_W       = 8,
    parameter int OPS_PER_CORE = 5,
    parameter int DEB_CYCLES   = 16
) (
    input  logic                        Clock_pin,
    input  logic                        Reset_pin,
    input  logic [SW_W-1:0]             SW_pin,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES*DISP_W-1:0] core_disp,
    output logic [NUM_CORES*SW_W-1:0]   core_sw,
    output logic [DISP_W-1:0]           Display_pin,
    output logic [IDX_W-1:0]            sel_core,
    output logic                        all_done,
    output logic [1:0]                  state_dbg
);

    localparam int OPS_W = $clog2(OPS_PER_CORE + 1);

    if (NUM_CORES < 2 || OPS_PER_CORE < 1 || DEB_CYCLES < 1 ||
        (1 << IDX_W) < NUM_CORES) begin : g_bad_param
        $error("multicore_io_arbiter: illegal parameter combination");
    end

    logic [SW_W-1:0]  sw_m;       // first synchroniser stage
    logic [SW_W-1:0]  sw_r;       // second synchroniser stage
    logic [SW_W-1:0]  sw_s;       // synchronised (and optionally debounced) switches
    logic             sw0_prev;   // sw_s[0] one clock ago
    logic             step;
    logic             done_all;
    logic             done_any;
    logic [OPS_W-1:0] ops_cnt;
    mcio_state_t      state;

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            sw_m     <= '0;
            sw_r     <= '0;
            sw0_prev <= 1'b0;
        end else begin
            sw_m     <= SW_pin;
            sw_r     <= sw_m;
            sw0_prev <= sw_s[0];
        end
    end

`ifdef MCIO_DEBOUNCE_EN
    logic sw0_db;

    mcio_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .Clock_pin (Clock_pin),
        .Reset_pin (Reset_pin),
        .din       (sw_r[0]),
        .dout      (sw0_db)
    );

    // Only the step button bounces; the level switches pass straight through.
    assign sw_s = {sw_r[SW_W-1:1], sw0_db};
`else
    assign sw_s = sw_r;
`endif

    // Step fires on the button release (falling edge), one clock wide.
    assign step     = sw0_prev & ~sw_s[0];
    assign done_all = &core_done;
    assign done_any = |core_done;

    assign state_dbg = state;

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            state       <= S_INPUT;
            sel_core    <= '0;
            ops_cnt     <= OPS_W'(OPS_PER_CORE);
            core_sw     <= '0;
            Display_pin <= '0;
            all_done    <= 1'b0;
        end else begin
            all_done <= (state == S_COMPLETE);
            case (state)
                S_INPUT: begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        core_sw[i*SW_W +: SW_W] <= sw_s;
                    end
                    Display_pin <= core_disp[DISP_W-1:0];
                    if (done_all) begin
                        state <= S_DISPLAY;
                    end else if (done_any) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Outputs hold; the step button is ignored here.
                    if (done_all) begin
                        state <= S_DISPLAY;
                    end else if (!done_any) begin
                        state <= S_INPUT;
                    end
                end
                S_DISPLAY: begin
                    core_sw[int'(sel_core)*SW_W +: SW_W] <= sw_s;
                    Display_pin <= core_disp[int'(sel_core)*DISP_W +: DISP_W];
                    if (!done_all) begin
                        // A core restarted: abandon the hand-off, a coincident step is lost.
                        state    <= S_INPUT;
                        sel_core <= '0;
                        ops_cnt  <= OPS_W'(OPS_PER_CORE);
                    end else if (step) begin
                        if (ops_cnt > OPS_W'(1)) begin
                            ops_cnt <= ops_cnt - OPS_W'(1);
                        end else begin
                            ops_cnt <= OPS_W'(OPS_PER_CORE);
                            if (int'(sel_core) < NUM_CORES - 1) begin
                                sel_core <= sel_core + IDX_W'(1);
                            end else begin
                                state <= S_COMPLETE;
                            end
                        end
                    end
                end
                S_COMPLETE: begin
                    core_sw     <= '0;
                    Display_pin <= {DISP_W{COMPLETE_DISP_BIT}};
                end
                default: begin
                    state <= S_INPUT;
                end
            endcase
        end
    end

endmodule
